// File: rtl/ioblock_pkg.sv
// ioblock_pkg: shared constants for the IO pin bank.
// Per-pin config layout {TSMUX[1:0], DORREG, OREG, TSREG}.
package ioblock_pkg;

  localparam int CFG_W = 5;

  localparam int TSMUX_HI = 4;
  localparam int TSMUX_LO = 3;
  localparam int DORREG   = 2;
  localparam int OREG     = 1;
  localparam int TSREG    = 0;

  localparam logic [1:0] TS_OFF  = 2'b00;
  localparam logic [1:0] TS_CTRL = 2'b01;
  localparam logic [1:0] TS_ON   = 2'b10;

endpackage

// File: rtl/ioblock_cell.sv
// ioblock_cell: one bidirectional pin datapath.
// Optional in/out/ts registers, tristate mux and pad driver.
module ioblock_cell
  import ioblock_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CFG_W-1:0] cfg,
  input  logic             fab_data,
  input  logic             fab_ts,
  output logic             fab_rd,
  inout  wire              pad
);

  logic       in_q;
  logic       oreg_q;
  logic       tsreg_q;
  logic       out_eff;
  logic       ts_eff;
  logic       drive;
  logic [1:0] tsmux;

  assign tsmux   = cfg[TSMUX_HI:TSMUX_LO];
  assign out_eff = cfg[OREG]  ? oreg_q  : fab_data;
  assign ts_eff  = cfg[TSREG] ? tsreg_q : fab_ts;

  // Pin registers capture every cycle; config only picks the mux path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q    <= 1'b0;
      oreg_q  <= 1'b0;
      tsreg_q <= 1'b0;
    end else begin
      in_q    <= pad;
      oreg_q  <= fab_data;
      tsreg_q <= fab_ts;
    end
  end

  // Output-enable decode from the tristate mode field.
  always_comb begin
    drive = 1'b0;
    unique case (1'b1)
      tsmux[1]:           drive = 1'b1;
      (tsmux == TS_CTRL): drive = ts_eff;
      (tsmux == TS_OFF):  drive = 1'b0;
      default:            drive = 1'b0;
    endcase
  end

  assign pad    = drive ? out_eff : 1'bz;
  assign fab_rd = cfg[DORREG] ? in_q : pad;

endmodule

// File: rtl/ioblock_bank.sv
// ioblock_bank: WIDTH bidirectional pins with serial config.
// Shadow chain loads MSB-first and applies atomically.
module ioblock_bank
  import ioblock_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             IOCLK,
  input  logic             IORSTN,
  inout  wire  [WIDTH-1:0] PIN,
  input  logic [WIDTH-1:0] OUT,
  input  logic [WIDTH-1:0] TS,
  output logic [WIDTH-1:0] IN,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  output logic             CFG_DONE,
  output logic             CFG_DOUT
);

  localparam int L     = CFG_W * WIDTH;
  localparam int CNT_W = $clog2(L + 1);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(L);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(L - 1);

  logic [L-1:0]     shadow;
  logic [L-1:0]     active;
  logic [L-1:0]     shadow_nxt;
  logic [CNT_W-1:0] count;
  logic             shift;

  assign shift      = CFG_EN && (count != FULL);
  assign shadow_nxt = {shadow[L-2:0], CFG_DIN};

  // Shift chain and bit counter; counter clears whenever CFG_EN drops.
  always_ff @(posedge IOCLK) begin
    if (!IORSTN) begin
      shadow <= '0;
      count  <= '0;
    end else if (shift) begin
      shadow <= shadow_nxt;
      count  <= count + 1'b1;
    end else if (!CFG_EN) begin
      count  <= '0;
    end
  end

  // Commit the full chain on the edge that shifts in the last bit.
  always_ff @(posedge IOCLK) begin
    if (!IORSTN) begin
      active   <= '0;
      CFG_DONE <= 1'b0;
    end else begin
      CFG_DONE <= 1'b0;
      if (shift && (count == LAST)) begin
        active   <= shadow_nxt;
        CFG_DONE <= 1'b1;
      end
    end
  end

  assign CFG_DOUT = shadow[L-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ioblock_cell u_cell (
      .clk      (IOCLK),
      .rst_n    (IORSTN),
      .cfg      (active[CFG_W*i +: CFG_W]),
      .fab_data (OUT[i]),
      .fab_ts   (TS[i]),
      .fab_rd   (IN[i]),
      .pad      (PIN[i])
    );
  end

endmodule

// File: tb/tb_ioblock_bank.sv
// tb_ioblock_bank: directed checks of the 2-pin bank.
// Hi-Z is observed by pulling the pad low against OUT=1.
module tb_ioblock_bank;

  localparam int W = 2;

  logic         IOCLK = 1'b0;
  logic         IORSTN;
  wire  [W-1:0] PIN;
  logic [W-1:0] OUT;
  logic [W-1:0] TS;
  logic [W-1:0] IN;
  logic         CFG_EN;
  logic         CFG_DIN;
  logic         CFG_DONE;
  logic         CFG_DOUT;

  logic [W-1:0] pad_en;
  logic [W-1:0] pad_drv;

  int n_chk;
  int n_fail;
  int done_seen;

  always #5 IOCLK = ~IOCLK;

  for (genvar i = 0; i < W; i++) begin : g_pad
    assign PIN[i] = pad_en[i] ? pad_drv[i] : 1'bz;
  end

  ioblock_bank #(.WIDTH(W)) dut (
    .IOCLK    (IOCLK),
    .IORSTN   (IORSTN),
    .PIN      (PIN),
    .OUT      (OUT),
    .TS       (TS),
    .IN       (IN),
    .CFG_EN   (CFG_EN),
    .CFG_DIN  (CFG_DIN),
    .CFG_DONE (CFG_DONE),
    .CFG_DOUT (CFG_DOUT)
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge IOCLK);
    #1;
    if (CFG_DONE === 1'b1) done_seen++;
  endtask

  task automatic send(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      CFG_EN  = 1'b1;
      CFG_DIN = bits[n-1-i];
      step();
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    done_seen = 0;
    IORSTN    = 1'b0;
    OUT       = 2'b11;
    TS        = 2'b11;
    CFG_EN    = 1'b0;
    CFG_DIN   = 1'b0;
    pad_en    = 2'b11;
    pad_drv   = 2'b10;

    step();
    step();
    #1;
    chk("rst_pin",  16'(PIN),      16'h2);
    chk("rst_in",   16'(IN),       16'h2);
    chk("rst_done", 16'(CFG_DONE), 16'h0);
    chk("rst_dout", 16'(CFG_DOUT), 16'h0);
    pad_drv = 2'b00;
    #1;
    chk("rst_hiz",  16'(PIN),      16'h0);

    IORSTN = 1'b1;
    OUT    = 2'b00;
    TS     = 2'b00;
    pad_en = 2'b00;
    step();

    // A: pin1 01_0_0_0, pin0 10_1_1_0
    done_seen = 0;
    send(16'b01000_10110, 10);
    chk("a_done",   16'(CFG_DONE),  16'h1);
    chk("a_dout",   16'(CFG_DOUT),  16'h0);
    CFG_EN = 1'b0;
    TS     = 2'b10;
    step();
    chk("a_done_lo", 16'(CFG_DONE), 16'h0);
    chk("a_pulses",  16'(done_seen), 16'h1);
    chk("a_pin0",    16'(PIN),       16'h0);
    OUT = 2'b01;
    #1;
    chk("a_oreg_n",  16'(PIN),       16'h0);
    step();
    chk("a_oreg_n1", 16'(PIN),       16'h1);
    OUT = 2'b11;
    #1;
    chk("a_ts_on",   16'(PIN),       16'h3);
    TS      = 2'b00;
    pad_en  = 2'b10;
    pad_drv = 2'b00;
    #1;
    chk("a_ts_off",  16'(PIN),       16'h1);

    // B: pin1 00_0_0_0, pin0 00_1_0_0
    OUT    = 2'b00;
    pad_en = 2'b00;
    step();
    done_seen = 0;
    send(16'b00000_00100, 10);
    chk("b_done",    16'(CFG_DONE),  16'h1);
    CFG_EN  = 1'b0;
    pad_en  = 2'b11;
    pad_drv = 2'b00;
    step();
    step();
    chk("b_in0",     16'(IN),        16'h0);
    pad_drv = 2'b11;
    #1;
    chk("b_in_n",    16'(IN),        16'h2);
    step();
    chk("b_in_n1",   16'(IN),        16'h3);

    // Partial load of 6 bits is discarded
    pad_drv   = 2'b00;
    done_seen = 0;
    send(16'b110110, 6);
    CFG_EN = 1'b0;
    OUT    = 2'b11;
    TS     = 2'b11;
    step();
    step();
    chk("p_pulses",  16'(done_seen), 16'h0);
    chk("p_hiz",     16'(PIN),       16'h0);
    chk("p_in",      16'(IN),        16'h0);

    // C: pin1 10_0_0_0, pin0 01_0_0_1
    pad_en    = 2'b00;
    done_seen = 0;
    send(16'b10000_01001, 10);
    chk("c_done",    16'(CFG_DONE),  16'h1);
    chk("c_dout",    16'(CFG_DOUT),  16'h1);
    chk("c_pulses",  16'(done_seen), 16'h1);
    CFG_EN = 1'b0;
    #1;
    chk("c_drive",   16'(PIN),       16'h3);
    TS = 2'b00;
    #1;
    chk("c_tsreg_n", 16'(PIN),       16'h3);
    step();
    pad_en  = 2'b01;
    pad_drv = 2'b00;
    #1;
    chk("c_tsreg_n1", 16'(PIN),      16'h2);

    // D: 14 bits, first 10 = pin1 01_0_0_0, pin0 10_0_0_0
    OUT       = 2'b00;
    pad_en    = 2'b00;
    done_seen = 0;
    send(16'b01000_10000_1111, 14);
    chk("d_pulses",  16'(done_seen), 16'h1);
    chk("d_dout",    16'(CFG_DOUT),  16'h0);
    CFG_EN  = 1'b0;
    step();
    OUT     = 2'b01;
    TS      = 2'b00;
    pad_en  = 2'b10;
    pad_drv = 2'b00;
    #1;
    chk("d_cfg_a",   16'(PIN),       16'h1);
    TS     = 2'b10;
    pad_en = 2'b00;
    #1;
    chk("d_cfg_b",   16'(PIN),       16'h1);
    OUT = 2'b11;
    #1;
    chk("d_cfg_c",   16'(PIN),       16'h3);

    // Reset in the middle of a load
    done_seen = 0;
    send(16'b11111, 5);
    IORSTN = 1'b0;
    step();
    IORSTN = 1'b1;
    CFG_EN = 1'b0;
    step();
    step();
    chk("r_pulses",  16'(done_seen), 16'h0);
    OUT     = 2'b11;
    TS      = 2'b11;
    pad_en  = 2'b11;
    pad_drv = 2'b00;
    #1;
    chk("r_hiz",     16'(PIN),       16'h0);
    chk("r_dout",    16'(CFG_DOUT),  16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
